// File: rtl/esn_pkg.sv
// Shared types and widths for the echo-state-network step scheduler.
package esn_pkg;

  localparam int unsigned ESN_U_W       = 16;
  localparam int unsigned ESN_ACC_W     = 32;
  localparam int unsigned ESN_STEP_W    = 16;
  localparam int unsigned ESN_N_NEURONS = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RES,
    S_RES_DR,
    S_RDO,
    S_RDO_DR,
    S_OUT
  } esn_sched_state_t;

  function automatic int unsigned esn_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/esn_sweep_ctr.sv
// Loadable index counter: counts up to LIMIT, flags it with tc, then wraps to 0.
module esn_sweep_ctr #(
  parameter int unsigned W     = 3,
  parameter int unsigned LIMIT = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == W'(LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/esn_step_sched.sv
// Per-step scheduler: latch sample, sweep reservoir, sweep readout, present estimate.
// ESN_WASHOUT_EN: when defined, the first WASHOUT steps skip OUT (no est_valid).
module esn_step_sched
  import esn_pkg::*;
#(
  parameter int unsigned N_NEURONS = ESN_N_NEURONS,
  parameter int unsigned IDX_W     = 3,
  parameter int unsigned RES_LAT   = 2,
  parameter int unsigned MAC_LAT   = 2,
  parameter int unsigned WASHOUT   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [ESN_U_W-1:0]    u_in,
  input  logic                  u_valid,
  output logic                  u_ready,
  output logic [ESN_U_W-1:0]    u_reg,
  output logic                  res_en,
  output logic [IDX_W-1:0]      res_idx,
  output logic                  mac_clr,
  output logic                  mac_en,
  output logic [IDX_W-1:0]      mac_idx,
  input  logic [ESN_ACC_W-1:0]  mac_acc,
  output logic [ESN_ACC_W-1:0]  est,
  output logic                  est_valid,
  input  logic                  est_ready,
  output logic                  busy,
  output logic [ESN_STEP_W-1:0] step_cnt
);

  // One drain counter serves both drain phases: it always ends at DR_MAX and
  // is preloaded so that the remaining count equals the phase latency.
  localparam int unsigned DR_MAX = esn_max(RES_LAT, MAC_LAT) - 1;
  localparam int unsigned DR_W   = (DR_MAX < 1) ? 1 : $clog2(DR_MAX + 1);
  localparam logic [DR_W-1:0] RES_DR_START = DR_W'(DR_MAX - (RES_LAT - 1));
  localparam logic [DR_W-1:0] MAC_DR_START = DR_W'(DR_MAX - (MAC_LAT - 1));

`ifdef ESN_WASHOUT_EN
  localparam bit WASHOUT_ON = 1'b1;
`else
  localparam bit WASHOUT_ON = 1'b0;
`endif

  esn_sched_state_t state_q, state_d;
  logic             res_tc, mac_tc, dr_tc;
  logic             dr_en, dr_load, capture, suppress;
  logic [DR_W-1:0]  dr_load_val, dr_cnt;

  assign suppress = WASHOUT_ON && (step_cnt < ESN_STEP_W'(WASHOUT));

  esn_sweep_ctr #(.W(IDX_W), .LIMIT(N_NEURONS - 1)) u_res_ctr (
    .clk(clk), .rst(rst), .en(res_en), .load(1'b0), .load_val('0),
    .cnt(res_idx), .tc(res_tc)
  );

  esn_sweep_ctr #(.W(IDX_W), .LIMIT(N_NEURONS - 1)) u_rdo_ctr (
    .clk(clk), .rst(rst), .en(mac_en), .load(1'b0), .load_val('0),
    .cnt(mac_idx), .tc(mac_tc)
  );

  esn_sweep_ctr #(.W(DR_W), .LIMIT(DR_MAX)) u_dr_ctr (
    .clk(clk), .rst(rst), .en(dr_en), .load(dr_load), .load_val(dr_load_val),
    .cnt(dr_cnt), .tc(dr_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    u_ready     = 1'b0;
    res_en      = 1'b0;
    mac_en      = 1'b0;
    mac_clr     = 1'b0;
    est_valid   = 1'b0;
    busy        = 1'b1;
    dr_en       = 1'b0;
    dr_load     = 1'b0;
    dr_load_val = RES_DR_START;
    capture     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy    = 1'b0;
        u_ready = ce;
        if (ce && u_valid) state_d = S_LOAD;
      end
      S_LOAD: begin
        mac_clr = ce;
        if (ce) state_d = S_RES;
      end
      S_RES: begin
        res_en = ce;
        if (ce && res_tc) begin
          state_d     = S_RES_DR;
          dr_load     = 1'b1;
          dr_load_val = RES_DR_START;
        end
      end
      S_RES_DR: begin
        dr_en = ce;
        if (ce && dr_tc) state_d = S_RDO;
      end
      S_RDO: begin
        mac_en = ce;
        if (ce && mac_tc) begin
          state_d     = S_RDO_DR;
          dr_load     = 1'b1;
          dr_load_val = MAC_DR_START;
        end
      end
      S_RDO_DR: begin
        dr_en = ce;
        if (ce && dr_tc) begin
          capture = 1'b1;
          state_d = suppress ? S_IDLE : S_OUT;
        end
      end
      S_OUT: begin
        est_valid = 1'b1;
        if (ce && est_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      u_reg    <= '0;
      est      <= '0;
      step_cnt <= '0;
    end else begin
      if (u_ready && u_valid) u_reg <= u_in;
      if (capture) begin
        est <= mac_acc;
        if (step_cnt != '1) step_cnt <= step_cnt + 1'b1;
      end
    end
  end

endmodule
